// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 inverse cipher types, tables and GF/key-schedule helpers
package aes_pkg;

  typedef enum logic [2:0] {ST_IDLE, ST_KEXP, ST_ARK, ST_ROUND, ST_DONE} state_t;

  localparam int NR = 10;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p = a;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] s0, s1, s2, s3;
    {s0, s1, s2, s3} = c;
    return {gf_mul(s0, 4'he) ^ gf_mul(s1, 4'hb) ^ gf_mul(s2, 4'hd) ^ gf_mul(s3, 4'h9),
            gf_mul(s0, 4'h9) ^ gf_mul(s1, 4'he) ^ gf_mul(s2, 4'hb) ^ gf_mul(s3, 4'hd),
            gf_mul(s0, 4'hd) ^ gf_mul(s1, 4'h9) ^ gf_mul(s2, 4'he) ^ gf_mul(s3, 4'hb),
            gf_mul(s0, 4'hb) ^ gf_mul(s1, 4'hd) ^ gf_mul(s2, 4'h9) ^ gf_mul(s3, 4'he)};
  endfunction

  // Byte 4*c+r is row r of column c; row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] fwd_key_step(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rc, 24'h0};
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] inv_key_step(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n3 = rk[31:0] ^ rk[63:32];
    n2 = rk[63:32] ^ rk[95:64];
    n1 = rk[95:64] ^ rk[127:96];
    n0 = rk[127:96] ^ sub_rot_word(n3) ^ {rc, 24'h0};
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/aes128_decrypt_top_if.sv
// rtl/aes128_decrypt_top_if.sv - start/result bundle of the AES-128 decrypt block
interface aes128_decrypt_top_if;
  logic         strt_btn;
  logic         reuse_key;
  logic [127:0] cipher_text;
  logic [127:0] key;
  logic [127:0] plain_text;
  logic         done;
  logic         busy;

  modport master (output strt_btn, reuse_key, cipher_text, key,
                  input  plain_text, done, busy);
  modport slave  (input  strt_btn, reuse_key, cipher_text, key,
                  output plain_text, done, busy);
endinterface

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round (last round skips InvMixColumns)
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [127:0] shifted;
  logic [127:0] added;
  logic [127:0] mixed;

  // InvShiftRows -> InvSubBytes -> AddRoundKey -> optional InvMixColumns
  always_comb begin
    shifted = inv_shift_rows(state_in);
    added = '0;
    for (int k = 0; k < 16; k++)
      added[127-8*k -: 8] = inv_sbox(shifted[127-8*k -: 8]) ^ rk[127-8*k -: 8];
    mixed = '0;
    for (int c = 0; c < 4; c++)
      mixed[127-32*c -: 32] = inv_mix_column(added[127-32*c -: 32]);
    state_out = last ? added : mixed;
  end

endmodule

// File: rtl/aes128_decrypt_top.sv
// rtl/aes128_decrypt_top.sv - iterative AES-128 decryptor with on-the-fly reverse key schedule
module aes128_decrypt_top
  import aes_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  aes128_decrypt_top_if.slave        io
);

  state_t       st_q;
  logic [127:0] blk_q;
  logic [127:0] rk_q;
  logic [127:0] rk10_q;
  logic [127:0] pt_q;
  logic         rk_valid_q;
  logic         done_q;
  logic         busy_q;
  logic [3:0]   cnt_q;

  logic [127:0] round_out;
  logic [127:0] rk_fwd;
  logic [127:0] rk_inv;
  logic [3:0]   inv_rc_idx;

  // ARK steps rk10 back to rk9 using rcon[10] regardless of how the counter arrived
  assign inv_rc_idx = (st_q == ST_ARK) ? 4'(NR) : cnt_q;
  assign rk_fwd     = fwd_key_step(rk_q, rcon(cnt_q));
  assign rk_inv     = inv_key_step(rk_q, rcon(inv_rc_idx));

  aes_inv_round u_round (
    .state_in  (blk_q),
    .rk        (rk_q),
    .last      (cnt_q == 4'd0),
    .state_out (round_out)
  );

  assign io.plain_text = pt_q;
  assign io.done       = done_q;
  assign io.busy       = busy_q;

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q       <= ST_IDLE;
      blk_q      <= '0;
      rk_q       <= '0;
      rk10_q     <= '0;
      pt_q       <= '0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= 4'd0;
    end else begin
      unique case (st_q)
        ST_IDLE, ST_DONE: begin
          if (io.strt_btn) begin
            blk_q  <= io.cipher_text;
            done_q <= 1'b0;
            busy_q <= 1'b1;
            if (io.reuse_key && rk_valid_q) begin
              rk_q <= rk10_q;
              st_q <= ST_ARK;
            end else begin
              rk_q  <= io.key;
              cnt_q <= 4'd1;
              st_q  <= ST_KEXP;
            end
          end
        end
        ST_KEXP: begin
          rk_q <= rk_fwd;
          if (cnt_q == 4'(NR)) begin
            rk10_q     <= rk_fwd;
            rk_valid_q <= 1'b1;
            st_q       <= ST_ARK;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_ARK: begin
          blk_q <= blk_q ^ rk_q;
          rk_q  <= rk_inv;
          cnt_q <= 4'(NR - 1);
          st_q  <= ST_ROUND;
        end
        ST_ROUND: begin
          blk_q <= round_out;
          if (cnt_q == 4'd0) begin
            pt_q   <= round_out;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            st_q   <= ST_DONE;
          end else begin
            rk_q  <= rk_inv;
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_decrypt_top.sv
// tb/tb_aes128_decrypt_top.sv - scoreboard bench for aes128_decrypt_top against a forward-cipher model
module tb_aes128_decrypt_top;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0;
  logic rst = 1'b0;

  aes128_decrypt_top_if io ();

  aes128_decrypt_top dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] pt;
    longint       t_done;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] sb[256];
  logic       done_prev = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map
  task automatic build_sbox();
    logic [7:0]  inv;
    logic [15:0] d;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      d = {inv, inv};
      sb[x] = inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
    end
  endtask

  // Forward AES-128 cipher; decrypting its output must give back the plain text
  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w[44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int b = 0; b < 16; b++) t[b] = sb[s[b]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*rnd + b/4][31-8*(b%4) -: 8];
    end
    o = '0;
    for (int b = 0; b < 16; b++) o[127-8*b -: 8] = s[b];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: every rising done pops one expectation and checks value, timing and busy
  always @(negedge clk) begin
    exp_t e;
    if (io.done === 1'b1 && done_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 with pt %h, want no result pending", io.plain_text);
      end else begin
        e = exp_q.pop_front();
        chk("plain_text", io.plain_text, e.pt);
        chk("done_time", 128'($time), 128'(e.t_done));
        chk("busy_at_done", {127'd0, io.busy}, 128'd0);
      end
    end
    done_prev = io.done;
  end

  // Called just after a negedge; the following posedge is the accept edge
  task automatic start(input logic [127:0] ct, input logic [127:0] k, input logic reuse,
                       input logic [127:0] exp_pt, input int lat);
    io.cipher_text = ct;
    io.key         = k;
    io.reuse_key   = reuse;
    io.strt_btn    = 1'b1;
    @(posedge clk);
    exp_q.push_back('{pt: exp_pt, t_done: longint'($time) + longint'(lat) * 10 + 5});
    #1;
    io.strt_btn = 1'b0;
    chk("busy_after_accept", {127'd0, io.busy}, 128'd1);
    chk("done_after_accept", {127'd0, io.done}, 128'd0);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (io.done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (io.done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: done low after %0d cycles, want high", name, n);
    end
  endtask

  initial begin
    logic [127:0] pt;
    logic [127:0] k;
    build_sbox();
    io.strt_btn    = 1'b0;
    io.reuse_key   = 1'b0;
    io.cipher_text = '0;
    io.key         = '0;
    repeat (3) @(negedge clk);
    chk("reset_plain_text", io.plain_text, 128'd0);
    chk("reset_done", {127'd0, io.done}, 128'd0);
    chk("reset_busy", {127'd0, io.busy}, 128'd0);
    rst = 1'b1;
    @(negedge clk);

    start(C1_CT, C1_KEY, 1'b0, C1_PT, 21);
    wait_done("c1");
    repeat (2) @(negedge clk);
    start(B_CT, B_KEY, 1'b0, B_PT, 21);
    wait_done("appb");
    @(negedge clk);
    start(B_CT, 128'd0, 1'b1, B_PT, 11);
    wait_done("reuse");

    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    start(C1_CT, C1_KEY, 1'b1, C1_PT, 21);
    wait_done("reuse_after_reset");
    start(C1_CT, C1_KEY, 1'b0, C1_PT, 21);
    wait_done("back_to_back");

    @(negedge clk);
    start(B_CT, B_KEY, 1'b0, B_PT, 21);
    repeat (4) @(negedge clk);
    io.cipher_text = rand128();
    io.reuse_key   = 1'b1;
    io.strt_btn    = 1'b1;
    @(posedge clk);
    #1;
    io.strt_btn = 1'b0;
    wait_done("ignored_start");

    @(negedge clk);
    start(C1_CT, C1_KEY, 1'b0, C1_PT, 21);
    repeat (14) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("midrun_reset_plain_text", io.plain_text, 128'd0);
    chk("midrun_reset_done", {127'd0, io.done}, 128'd0);
    chk("midrun_reset_busy", {127'd0, io.busy}, 128'd0);
    @(negedge clk);
    rst = 1'b1;
    start(B_CT, B_KEY, 1'b1, B_PT, 21);
    wait_done("after_midrun_reset");

    k = '0;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pt = rand128();
      if (i % 2 == 0) begin
        k = rand128();
        start(model_encrypt(pt, k), k, 1'b0, pt, 21);
      end else begin
        start(model_encrypt(pt, k), rand128(), 1'b1, pt, 11);
      end
      wait_done("random");
    end

    @(negedge clk);
    chk("pending_results", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes128_decrypt_top.md
# aes128_decrypt_top

Iterative, area-optimised AES-128 inverse cipher (FIPS-197 InvCipher): the receive-side counterpart of the team's AES-128 encryption toplevel. It accepts a 128-bit cipher text and the 128-bit cipher key and returns the plain text. Rounds are computed one per cycle over a single shared inverse-round datapath. The last-round key is derived by a forward key-expansion pass, and round keys are then regenerated backwards on the fly, so no key storage is needed beyond two 128-bit registers.

## Interface

- No parameters; block is fixed at AES-128 (Nk=4, Nr=10).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `strt_btn` in 1: start request; sampled only in IDLE or DONE.
- `reuse_key` in 1: qualifies `strt_btn`; skip key expansion and use the stored last-round key.
- `cipher_text` in 128: input block, byte 0 in bits [127:120].
- `key` in 128: cipher key, same byte order.
- `plain_text` out 128: result, held until the next accepted start.
- `done` out 1: level; high while `plain_text` is valid.
- `busy` out 1: high from the accept edge until the result is written.

## Operation

- States: IDLE, KEXP, ARK, ROUND, DONE.
- Reset (`rst`=0 at an edge): state=IDLE, `plain_text`=0, `done`=0, `busy`=0, `rk_valid`=0, round counter=0. Reset overrides any operation in progress; a partial result never appears.
- IDLE/DONE with `strt_btn`=1:
  - Capture `cipher_text` into the state register and clear `done`.
  - If `reuse_key`=1 and `rk_valid`=1: load the round-key register from the stored rk10 and go to ARK.
  - Otherwise: load `key` into the round-key register and go to KEXP, counter=1.
- KEXP: ten forward key-schedule steps, one per cycle, using rcon[counter].
  - After step 10 the register holds rk10; copy it into the rk10 store and set `rk_valid`=1.
  - Go to ARK.
- ARK: state ^= rk10. Round key steps back to rk9 via the inverse schedule with rcon[10]. Counter=9. Go to ROUND.
- Inverse schedule step: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^rcon.
- ROUND, counter r = 9..1: state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_r). Round key steps to rk_{r-1}. Decrement the counter.
- ROUND, counter r = 0: result = InvSubBytes(InvShiftRows(state)) ^ rk0, written to `plain_text`. Set `done`=1, `busy`=0, go to DONE.
- `strt_btn` during KEXP/ARK/ROUND is ignored and not queued.
- `reuse_key`=1 with `rk_valid`=0 behaves as `reuse_key`=0.
- DONE with `strt_btn`=0: hold all outputs indefinitely.

## Timing

- Edge 0 is the rising edge that accepts start.
- Full path: KEXP occupies edges 1–10, ARK edge 11, ROUND edges 12–21. `plain_text` and `done` are valid after edge 21, so latency is 21 cycles.
- Reuse path: ARK at edge 1, ROUND at edges 2–11. Latency is 11 cycles.
- `busy` is high after edge 0 and low after the final edge. `done` is low during that same interval.
- Back-to-back operation: a start is accepted in the first DONE cycle. `done` falls at that edge.
- Combinational path per cycle: one inverse round plus one key step. All outputs are registered.

## Structure

- Package `aes_pkg`:
  - sbox and inv_sbox functions;
  - rcon table [1..10];
  - xtime, gf_mul, inv_mix_column and inv_shift_rows functions;
  - the state enum;
  - the NR=10 constant.
- Sub-module `aes_inv_round` (combinational):
  - inputs: state, round key, `last` flag;
  - output: next state;
  - `last`=1 bypasses InvMixColumns.
- Key-schedule steps (forward and inverse) are package functions instantiated in the top.

## Test plan

- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a, `reuse_key`=0 -> `plain_text`=00112233445566778899aabbccddeeff, `done` rises exactly 21 cycles after accept.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734.
- Key reuse: after the App. B run, start with `reuse_key`=1, ct 3925841d02dc09fbdc118597196a0b32, `key` bus=0 -> same pt after 11 cycles.
- Reuse after reset: pulse `rst` low, then start with `reuse_key`=1 on the C.1 vectors -> full 21-cycle path, correct pt.
- Mid-operation: assert `strt_btn` at cycle 5 of a run -> ignored, first result unchanged. Drive `rst`=0 at cycle 15 -> outputs 0, `done`=0, IDLE next cycle.
- Back-to-back: start again in the first DONE cycle with C.1 -> `done` drops at that edge and returns 21 cycles later with the C.1 pt.
